// File: rtl/bcd_scan_counter.sv
// Four-digit packed-BCD up/down counter with wrap carry
// and a time-multiplexed digit scanner for a 7-seg decoder.
module bcd_scan_counter #(
  parameter int SCAN_DIV = 1000,
  parameter int DIV_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      step_val;
  logic             step_wrap;
  logic             rip;
  logic [15:0]      load_clamp;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  // Ripple carry/borrow across digits; surviving rip means full wrap
  always_comb begin
    step_val = count;
    rip      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rip) begin
        if (up) begin
          if (count[4*i +: 4] >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
            rip = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
            rip = 1'b0;
          end
        end
      end
    end
    step_wrap = rip;
  end

  always_comb begin
    load_clamp = load_val;
    for (int i = 0; i < 4; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        load_clamp[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
      carry <= 1'b0;
    end else if (load) begin
      count <= load_clamp;
      carry <= 1'b0;
    end else if (en) begin
      count <= step_val;
      carry <= step_wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_MAX) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    an      = 4'b0001 << idx;
    bcd_out = 4'h0;
    unique case (idx)
      2'd0: bcd_out = count[3:0];
      2'd1: bcd_out = count[7:4];
      2'd2: bcd_out = count[11:8];
      2'd3: bcd_out = count[15:12];
    endcase
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized self-checking bench for bcd_scan_counter against
// a decimal-integer reference model (SCAN_DIV = 4).
module tb_bcd_scan_counter;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd_out;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  int m_val = 0;
  bit m_carry = 1'b0;
  int m_scan = 0;

  bcd_scan_counter #(.SCAN_DIV(SD), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(count), .carry(carry),
    .bcd_out(bcd_out), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_dec(input logic [15:0] v);
    int r = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(v[4*i +: 4]);
      r += ((n > 9) ? 9 : n) * w;
      w *= 10;
    end
    return r;
  endfunction

  // {count, carry, an, bcd_out} the model expects right now
  function automatic logic [24:0] expv();
    int k = (m_scan / SD) % 4;
    logic [15:0] b = to_bcd(m_val);
    return {b, m_carry, 4'(1 << k), b[4*k +: 4]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    m_scan++;
    if (load) begin
      m_val = clamp_dec(load_val);
      m_carry = 1'b0;
    end else if (en) begin
      if (up) begin
        m_carry = (m_val == 9999);
        m_val = (m_val + 1) % 10000;
      end else begin
        m_carry = (m_val == 0);
        m_val = (m_val + 9999) % 10000;
      end
    end else begin
      m_carry = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    en = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b0;
    m_val = 0;
    m_carry = 1'b0;
    m_scan = 0;
  endtask

  task automatic test_reset();
    logic [24:0] g;
    rst = 1'b0;
    m_scan = 0;
    en = 1'b1;
    up = 1'b1;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    g = {count, carry, an, bcd_out};
    checks++;
    if (g !== {16'h0000, 1'b0, 4'b0001, 4'h0}) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", g,
               {16'h0000, 1'b0, 4'b0001, 4'h0});
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_val = 0;
    m_carry = 1'b0;
    m_scan = 0;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] wa = (i < 3) ? 4'b0001 : 4'b0010;
      tick();
      checks++;
      if (an !== wa) begin
        errors++;
        $display("FAIL reset_scan_hold c%0d an=%b want=%b", i, an, wa);
      end
    end
  endtask

  task automatic test_increment();
    do_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 33; i++) begin
      logic [24:0] g;
      tick();
      g = {count, carry, an, bcd_out};
      checks++;
      if (g !== expv()) begin
        errors++;
        $display("FAIL increment c%0d got=%h want=%h", i, g, expv());
      end
      if (i == 9) begin
        checks++;
        if (count !== 16'h0010) begin
          errors++;
          $display("FAIL inc_10 count=%h want=0010", count);
        end
      end
    end
    checks++;
    if (count !== 16'h0033 || carry !== 1'b0) begin
      errors++;
      $display("FAIL inc_33 count=%h carry=%b want=0033/0",
               count, carry);
    end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [15:0] wc [3] = '{16'h9999, 16'h0000, 16'h0000};
    bit          wk [3] = '{1'b0, 1'b1, 1'b0};
    load = 1'b1;
    load_val = 16'h9998;
    tick();
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) en = 1'b0;
      tick();
      checks++;
      if (count !== wc[i] || carry !== wk[i] ||
          {count, carry, an, bcd_out} !== expv()) begin
        errors++;
        $display("FAIL up_wrap c%0d count=%h carry=%b want=%h/%b",
                 i, count, carry, wc[i], wk[i]);
      end
    end
  endtask

  task automatic test_down();
    load = 1'b1;
    load_val = 16'h0100;
    tick();
    load = 1'b0;
    en = 1'b1;
    up = 1'b0;
    tick();
    checks++;
    if (count !== 16'h0099 || carry !== 1'b0) begin
      errors++;
      $display("FAIL down_step count=%h carry=%b want=0099/0",
               count, carry);
    end
    load = 1'b1;
    load_val = 16'h0000;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (count !== 16'h9999 || carry !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap count=%h carry=%b want=9999/1",
               count, carry);
    end
    tick();
    checks++;
    if (count !== 16'h9998 || carry !== 1'b0 ||
        {count, carry, an, bcd_out} !== expv()) begin
      errors++;
      $display("FAIL down_after count=%h carry=%b want=9998/0",
               count, carry);
    end
    en = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] wa [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] wb [5] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      int s = i / SD;
      if (i == 0) begin
        load = 1'b1;
        load_val = 16'h1234;
      end
      // index i here is the state before the edge at i+1
      if (i > 0) begin
        checks++;
        if (an !== wa[s] || bcd_out !== wb[s]) begin
          errors++;
          $display("FAIL scan c%0d an=%b bcd=%h want=%b/%h",
                   i, an, bcd_out, wa[s], wb[s]);
        end
      end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic test_load_priority();
    logic [15:0] lv [2] = '{16'h0500, 16'hA5F3};
    logic [15:0] wc [2] = '{16'h0500, 16'h9593};
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load = 1'b1;
      load_val = lv[i];
      tick();
      checks++;
      if (count !== wc[i] || carry !== 1'b0) begin
        errors++;
        $display("FAIL load_prio v=%h count=%h carry=%b want=%h/0",
                 lv[i], count, carry, wc[i]);
      end
    end
    load = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [24:0] g;
      int r = int'($urandom_range(0, 99));
      load = (r < 8);
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      tick();
      g = {count, carry, an, bcd_out};
      checks++;
      if (g !== expv()) begin
        errors++;
        $display("FAIL random c%0d got=%h want=%h", i, g, expv());
      end
    end
    load = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    test_increment();
    test_up_wrap();
    test_down();
    test_scan();
    test_load_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Four-digit packed-BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-7-segment decoder.
- Each scan slot presents one BCD digit (bcd_out, to the decoder's 4-bit input) and a one-hot digit select (an) for the display common lines.
- Provides synchronous load, count enable, direction control and a wrap-around carry pulse.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit is held on bcd_out/an before advancing (must be >= 1).
- DIV_W, 10, divider width; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one BCD step per clk cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  16  four packed BCD digits, [3:0] = units … [15:12] = thousands.
- count  output  16  registered packed-BCD count value.
- carry  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down).
- bcd_out  output  4  BCD digit currently being scanned; feeds the decoder.
- an  output  4  one-hot digit select, active-high; bit i = digit i.

Behaviour:
- Reset (async assert, takes effect immediately, independent of clk):
  - count = 0x0000, carry = 0.
  - scan index = 0, divider = 0.
  - an = 4'b0001, bcd_out = 4'h0.
- Reset release: normal operation starts on the first rising clk edge with rst low.
- Priority per edge: load > en > hold.
- Load:
  - count <= load_val, except any nibble > 9 is stored as 9 (per nibble).
  - carry <= 0.
  - No count step that cycle, even when en = 1.
- Increment (en = 1, up = 1):
  - Units digit +1. A digit at 9 becomes 0 and propagates +1 to the next digit (ripple within one cycle).
  - 9999 -> 0000 sets carry = 1 for exactly the cycle in which count shows 0000.
- Decrement (en = 1, up = 0):
  - Units digit -1. A digit at 0 becomes 9 and propagates a borrow.
  - 0000 -> 9999 sets carry = 1 for exactly the cycle in which count shows 9999.
- Hold (en = 0, load = 0): count unchanged, carry <= 0.
- carry is registered and updates on the same edge as count. Consecutive wraps are impossible, so carry never stays high two cycles.
- Count latency: count reflects load/step one clk edge after the inputs are sampled.
- Scanner:
  - The divider runs continuously, independent of en/load.
  - Divider counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and the scan index advances 0->1->2->3->0.
- Scanner outputs:
  - an = 1 << index.
  - bcd_out = count nibble[index]; combinational from registered index and count.
  - A count change is visible on bcd_out in the same cycle it appears on count.
- Each digit is held exactly SCAN_DIV cycles. Full scan period = 4*SCAN_DIV cycles.
- SCAN_DIV = 1: index advances every cycle.
- an is always exactly one-hot, including at reset; never all-zero or multi-hot.
- Reset mid-scan or mid-count: all state returns to reset values immediately; scan restarts at digit 0 with a full SCAN_DIV hold.

Test Plan:
- Reset: run counting with SCAN_DIV=4, assert rst between edges -> immediately count=0x0000, an=0001, bcd_out=0, carry=0. After release, an stays 0001 for 4 cycles.
- Increment: from reset, en=1, up=1 for 10 cycles -> count=0x0010. For 23 more cycles -> count=0x0033. carry=0 throughout.
- Up-wrap: load 0x9998, then en=1, up=1 for 2 cycles -> count 0x9999 then 0x0000. carry=1 only in the 0x0000 cycle, 0 the next cycle.
- Down-count and down-wrap: load 0x0100, en=1, up=0, 1 cycle -> 0x0099. Load 0x0000, 1 down step -> 0x9999 with carry=1 for one cycle.
- Scan (SCAN_DIV=4): load 0x1234, en=0.
  - an sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
  - Paired bcd_out = 4, 3, 2, 1, 4.
- Load priority and clamp:
  - load=1 with en=1, up=1, load_val=0x0500 -> count=0x0500 (not 0x0501), carry=0.
  - load_val=0xA5F3 -> count=0x9593.
